time_keeper: RTL

//  Time-of-day core for the alarm clock. Runs on the 1 kHz system clock and keeps a 24 h
//  BCD time (HH:MM:SS), advanced once per second by an internal prescaler.

---
 rtl/clock_defs.sv | 25 ++
 rtl/bcd_digit_counter.sv | 27 ++
 rtl/time_keeper.sv | 96 +++++++++
 3 files changed

// File: rtl/clock_defs.sv
// Shared time-of-day definitions: digit limits, the HH:MM record used by the
// time keeper and the alarm stage, and the load validity check.
package clock_defs;

    localparam int unsigned MAX_H_TEN      = 2;
    localparam int unsigned MAX_H_ONE_AT_2 = 3;
    localparam int unsigned MAX_M_TEN      = 5;
    localparam int unsigned BCD_MAX        = 9;

    typedef struct packed {
        logic [3:0] h_ten;
        logic [3:0] h_one;
        logic [3:0] m_ten;
        logic [3:0] m_one;
    } bcd_time;

    function automatic logic is_valid_hhmm(input bcd_time t);
        return (t.h_ten <= 4'(MAX_H_TEN)) &&
               (t.h_one <= 4'(BCD_MAX))   &&
               (t.m_ten <= 4'(MAX_M_TEN)) &&
               (t.m_one <= 4'(BCD_MAX))   &&
               !((t.h_ten == 4'(MAX_H_TEN)) && (t.h_one > 4'(MAX_H_ONE_AT_2)));
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: wraps MAX -> 0 on inc, load has priority, carry is combinational.
module bcd_digit_counter #(
    parameter int unsigned MAX = 9,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q,
    output logic         carry
);

    assign carry = inc && (q == W'(MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= (q == W'(MAX)) ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24 h BCD time-of-day keeper with per-second prescaler, HH:MM load and event pulses.
module time_keeper
    import clock_defs::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned PS_W     = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_en,
    input  logic       set_load,
    input  logic [3:0] set_h_ten,
    input  logic [3:0] set_h_one,
    input  logic [3:0] set_m_ten,
    input  logic [3:0] set_m_one,
    output logic [3:0] h_ten,
    output logic [3:0] h_one,
    output logic [3:0] m_ten,
    output logic [3:0] m_one,
    output logic [3:0] s_ten,
    output logic [3:0] s_one,
    output logic       sec_tick,
    output logic       min_tick,
    output logic       day_wrap,
    output logic       load_err
);

    logic [PS_W-1:0] ps;
    logic            tick;
    logic            load_ok;
    logic            set_valid;
    bcd_time         set_t;
    logic            c_s1, c_s10, c_m1, c_m10, c_h1, c_h10;
    logic            at_23;
    logic            hr_wrap;

    assign set_t     = '{h_ten: set_h_ten, h_one: set_h_one, m_ten: set_m_ten, m_one: set_m_one};
    assign set_valid = is_valid_hhmm(set_t);
    assign load_ok   = set_load && set_valid;
    assign tick      = run_en && (ps == PS_W'(TICK_DIV - 1));

    // Hours are two plain BCD digits; the 23 -> 00 limit is forced through their load path.
    assign at_23   = (h_ten == 4'(MAX_H_TEN)) && (h_one == 4'(MAX_H_ONE_AT_2));
    assign hr_wrap = (c_m10 && at_23) || c_h10;

    bcd_digit_counter #(.MAX(BCD_MAX), .W(4)) u_s_one (
        .clk(clk), .rst(rst), .inc(tick), .load(load_ok), .load_val('0),
        .q(s_one), .carry(c_s1));

    bcd_digit_counter #(.MAX(5), .W(4)) u_s_ten (
        .clk(clk), .rst(rst), .inc(c_s1), .load(load_ok), .load_val('0),
        .q(s_ten), .carry(c_s10));

    bcd_digit_counter #(.MAX(BCD_MAX), .W(4)) u_m_one (
        .clk(clk), .rst(rst), .inc(c_s10), .load(load_ok), .load_val(set_m_one),
        .q(m_one), .carry(c_m1));

    bcd_digit_counter #(.MAX(MAX_M_TEN), .W(4)) u_m_ten (
        .clk(clk), .rst(rst), .inc(c_m1), .load(load_ok), .load_val(set_m_ten),
        .q(m_ten), .carry(c_m10));

    bcd_digit_counter #(.MAX(BCD_MAX), .W(4)) u_h_one (
        .clk(clk), .rst(rst), .inc(c_m10), .load(load_ok || hr_wrap),
        .load_val(load_ok ? set_h_one : '0),
        .q(h_one), .carry(c_h1));

    bcd_digit_counter #(.MAX(MAX_H_TEN), .W(4)) u_h_ten (
        .clk(clk), .rst(rst), .inc(c_h1), .load(load_ok || hr_wrap),
        .load_val(load_ok ? set_h_ten : '0),
        .q(h_ten), .carry(c_h10));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps <= '0;
        end else if (load_ok || tick) begin
            ps <= '0;
        end else if (run_en) begin
            ps <= ps + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_tick <= 1'b0;
            min_tick <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sec_tick <= tick && !load_ok;
            min_tick <= c_s10 && !load_ok;
            day_wrap <= hr_wrap && !load_ok;
            load_err <= set_load && !set_valid;
        end
    end

endmodule
